// File: rtl/interp_sel_scheduler_if.sv
// Handshake bundle between the interpolation select scheduler and its driver.
// Member suffixes (_i/_o) are given from the scheduler's point of view.
interface interp_sel_scheduler_if;
  logic       start_i;
  logic       abort_i;
  logic       ready_i;
  logic [4:0] phase_mask_i;
  logic [7:0] sel_o;
  logic       sel_valid_o;
  logic       mux_valid_o;
  logic [2:0] phase_o;
  logic       busy_o;
  logic       done_o;

  modport slave (
    input  start_i, abort_i, ready_i, phase_mask_i,
    output sel_o, sel_valid_o, mux_valid_o, phase_o, busy_o, done_o
  );

  modport master (
    output start_i, abort_i, ready_i, phase_mask_i,
    input  sel_o, sel_valid_o, mux_valid_o, phase_o, busy_o, done_o
  );
endinterface

// File: rtl/interp_sel_scheduler.sv
// Walks the row/column mux select through the integer and half-pel phases of one block.
// Define SCHED_PHASE_MASK_EN to honour phase_mask_i; otherwise all five phases always run.
module interp_sel_scheduler #(
  parameter int unsigned NUM_PIXEL = 8
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  interp_sel_scheduler_if.slave  bus
);

  // Contiguous index ranges; HALF_C must stay <= 255 for 8-bit arithmetic.
  localparam logic [7:0] INT_ROWS = 8'(NUM_PIXEL + 8);
  localparam logic [7:0] INT_COLS = 8'(NUM_PIXEL + 8 + NUM_PIXEL);
  localparam logic [7:0] HALF_A   = 8'(NUM_PIXEL + 8 + 2 * NUM_PIXEL);
  localparam logic [7:0] HALF_B   = 8'(NUM_PIXEL + 8 + 3 * NUM_PIXEL);
  localparam logic [7:0] HALF_C   = 8'(NUM_PIXEL + 8 + 4 * NUM_PIXEL);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INT_ROW = 3'd1;
  localparam logic [2:0] S_INT_COL = 3'd2;
  localparam logic [2:0] S_HALF_A  = 3'd3;
  localparam logic [2:0] S_HALF_B  = 3'd4;
  localparam logic [2:0] S_HALF_C  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // First enabled phase strictly after cur, or DONE when none is left.
  function automatic logic [2:0] next_phase(input logic [2:0] cur, input logic [4:0] mask);
    logic [2:0] nxt;
    nxt = S_DONE;
    if (cur < S_HALF_C  && mask[4]) nxt = S_HALF_C;
    if (cur < S_HALF_B  && mask[3]) nxt = S_HALF_B;
    if (cur < S_HALF_A  && mask[2]) nxt = S_HALF_A;
    if (cur < S_INT_COL && mask[1]) nxt = S_INT_COL;
    if (cur < S_INT_ROW && mask[0]) nxt = S_INT_ROW;
    return nxt;
  endfunction

  function automatic logic [7:0] phase_base(input logic [2:0] ph);
    case (ph)
      S_INT_COL: return INT_ROWS;
      S_HALF_A:  return INT_COLS;
      S_HALF_B:  return HALF_A;
      S_HALF_C:  return HALF_B;
      default:   return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] phase_last(input logic [2:0] ph);
    case (ph)
      S_INT_ROW: return INT_ROWS - 8'd1;
      S_INT_COL: return INT_COLS - 8'd1;
      S_HALF_A:  return HALF_A - 8'd1;
      S_HALF_B:  return HALF_B - 8'd1;
      default:   return HALF_C - 8'd1;
    endcase
  endfunction

  logic [2:0] state_q, state_d;
  logic [7:0] sel_q, sel_d;
  logic [4:0] mask_q, mask_d;
  logic       sel_valid_q, mux_valid_q, busy_q, done_q;
  logic       busy_d;
  logic [4:0] mask_eff;

`ifdef SCHED_PHASE_MASK_EN
  assign mask_eff = bus.phase_mask_i;
`else
  assign mask_eff = 5'b11111;
`endif

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path infers a latch.
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          mask_d  = mask_eff;
          state_d = next_phase(S_IDLE, mask_eff);
          sel_d   = phase_base(state_d);
        end
      end
      S_INT_ROW, S_INT_COL, S_HALF_A, S_HALF_B, S_HALF_C: begin
        if (bus.ready_i) begin
          if (sel_q == phase_last(state_q)) begin
            state_d = next_phase(state_q, mask_q);
            sel_d   = phase_base(state_d);
          end else begin
            sel_d = sel_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = 8'd0;
      end
    endcase
    if (bus.abort_i) begin
      state_d = S_IDLE;
      sel_d   = 8'd0;
    end
  end

  assign busy_d = (state_d >= S_INT_ROW) && (state_d <= S_HALF_C);

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      sel_q       <= 8'd0;
      mask_q      <= 5'd0;
      sel_valid_q <= 1'b0;
      mux_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mask_q      <= mask_d;
      sel_valid_q <= busy_d;
      mux_valid_q <= sel_valid_q & bus.ready_i;
      busy_q      <= busy_d;
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bus.sel_o       = sel_q;
  assign bus.sel_valid_o = sel_valid_q;
  assign bus.mux_valid_o = mux_valid_q;
  assign bus.phase_o     = state_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;

endmodule

// File: doc/interp_sel_scheduler.md
INTERP_SEL_SCHEDULER -- requirements
Module: interp_sel_scheduler

Interface
REQ-001 Parameter NUM_PIXEL, default 8, block edge in pixels; derived bounds INT_ROWS=NUM_PIXEL+8, INT_COLS=INT_ROWS+NUM_PIXEL, HALF_A=INT_COLS+NUM_PIXEL, HALF_B=HALF_A+NUM_PIXEL, HALF_C=HALF_B+NUM_PIXEL (16/24/32/40/48 at default).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-004 start  input  1  one-cycle request to sequence one block.
REQ-005 abort  input  1  terminate the current sequence without done.
REQ-006 ready  input  1  downstream filter accepts the current mux row this cycle.
REQ-007 phase_mask  input  5  enable per phase: bit0 INT_ROW, bit1 INT_COL, bit2 HALF_A, bit3 HALF_B, bit4 HALF_C.
REQ-008 sel  output  8  select index driven to the row/column input mux.
REQ-009 sel_valid  output  1  sel holds a meaningful index this cycle.
REQ-010 mux_valid  output  1  the mux output register holds the row for an accepted sel (one cycle after sel_valid & ready).
REQ-011 phase  output  3  current state code: 0 IDLE, 1 INT_ROW, 2 INT_COL, 3 HALF_A, 4 HALF_B, 5 HALF_C, 6 DONE.
REQ-012 busy  output  1  high in states 1-5.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, INT_ROW, INT_COL, HALF_A, HALF_B, HALF_C, DONE, with registered outputs.
REQ-015 In IDLE, when start=1, the FSM SHALL latch phase_mask and enter the first enabled phase in order INT_ROW..HALF_C, loading sel with that phase's base (0, INT_ROWS, INT_COLS, HALF_A, HALF_B).
REQ-016 If no phase is enabled at start, the FSM SHALL go directly to DONE.
REQ-017 In a phase state, sel_valid SHALL be 1; sel SHALL advance by 1 only on cycles with ready=1; with ready=0, sel and state SHALL hold.
REQ-018 When ready=1 and sel equals the phase's last index (bound-1), the FSM SHALL move to the next enabled phase and load its base, or to DONE if none remains; there SHALL be no gap cycle between phases.
REQ-019 DONE SHALL last exactly one cycle with done=1, sel_valid=0, then return to IDLE.
REQ-020 mux_valid SHALL equal sel_valid & ready registered by one cycle, matching the one-cycle registered mux latency.
REQ-021 start while busy or in DONE SHALL be ignored; phase_mask changes after start SHALL have no effect until the next start.
REQ-022 abort=1 in any state SHALL force IDLE on the next edge, with sel=0 and sel_valid=0, without a done pulse; abort SHALL take priority over start and ready.
REQ-023 In IDLE and DONE, sel SHALL read 0 and sel_valid 0; sel SHALL never exceed HALF_C-1.
REQ-024 All index arithmetic SHALL be 8-bit unsigned; NUM_PIXEL SHALL be restricted so that HALF_C <= 255.

Reset
REQ-025 With reset=0 at an edge: state IDLE, sel=0, sel_valid=0, mux_valid=0, phase=0, busy=0, done=0, latched mask=0.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; reset SHALL take priority over abort and start.

Configuration
REQ-027 Macro SCHED_PHASE_MASK_EN: when defined, phase_mask SHALL behave as in REQ-007/015/016; when undefined, the phase_mask port SHALL remain present but be ignored and all five phases SHALL always run (latched mask = 5'b11111).

Verification
REQ-028 NUM_PIXEL=8, mask=11111, ready=1 held, start pulse -> sel 0..47 on 48 consecutive cycles, phase 1..5 at boundaries 0/16/24/32/40, done on cycle 49, mux_valid on cycles 2..49.
REQ-029 Same run with ready low on every third cycle -> sel holds each time, 48 accepted indices with no skip or repeat, mux_valid count = 48.
REQ-030 mask=10100 (SCHED_PHASE_MASK_EN defined) -> sel 24..31 then 40..47 back-to-back, done after 16 accepted cycles; undefined -> full 0..47 sequence.
REQ-031 mask=00000 -> done one cycle after start, sel_valid never 1.
REQ-032 abort at sel=20, and separately reset=0 at sel=35 -> IDLE the next cycle, sel=0, no done; a following start runs the full sequence correctly.
REQ-033 start pulsed at sel=10 and during DONE -> ignored; exactly one done per accepted start.
